// File: rtl/risc_datapath.sv
// VeriRisc datapath: PC, IR, ACC and ALU driven by the controller strobes, with a synchronous-read memory port.
// State updates one edge after a strobe; no backpressure. Optional INSTR_COUNT_EN adds a 16-bit fetch counter (icount).
module risc_datapath #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic              ld_ir,
  input  logic              ld_acc,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              halt,
  input  logic              data_e,
  input  logic              sel,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_oe,
  output logic [2:0]        opcode,
  output logic              zero,
  output logic [AWIDTH-1:0] pc,
  output logic              halted
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]       icount
`endif
);

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;

  logic [AWIDTH-1:0] pc_q;
  logic [DWIDTH-1:0] ir_q;
  logic [DWIDTH-1:0] acc_q;
  logic              halted_q;
  logic [DWIDTH-1:0] alu_res;
  logic              run;

  assign run = ~halted_q;

  // Bus strobes are also gated by reset so nothing reaches memory while held in reset.
  assign mem_addr  = sel ? pc_q : ir_q[AWIDTH-1:0];
  assign mem_re    = rd & run & rst;
  assign mem_we    = wr & run & rst;
  assign mem_oe    = data_e & run & rst;
  assign mem_wdata = acc_q;
  assign zero      = (acc_q == '0);
  assign opcode    = ir_q[DWIDTH-1 -: 3];
  assign pc        = pc_q;
  assign halted    = halted_q;

  always_comb begin
    alu_res = acc_q;
    case (opcode)
      OP_ADD:  alu_res = acc_q + mem_rdata;
      OP_AND:  alu_res = acc_q & mem_rdata;
      OP_XOR:  alu_res = acc_q ^ mem_rdata;
      OP_LDA:  alu_res = mem_rdata;
      default: alu_res = acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      ir_q     <= '0;
      acc_q    <= '0;
      halted_q <= 1'b0;
    end else if (run) begin
      if (halt)   halted_q <= 1'b1;
      if (ld_ir)  ir_q     <= mem_rdata;
      if (ld_acc) acc_q    <= alu_res;
      if (ld_pc)
        pc_q <= ir_q[AWIDTH-1:0];
      else if (inc_pc)
        pc_q <= pc_q + AWIDTH'(1);
    end
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] icount_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      icount_q <= '0;
    else if (run && ld_ir)
      icount_q <= icount_q + 16'd1;
  end

  assign icount = icount_q;
`endif

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: reset, ALU ops, PC control, STO bus, halt freeze, optional fetch counter.
module tb_risc_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e, sel;
  logic [7:0] mem_rdata;
  logic [4:0] mem_addr;
  logic       mem_re, mem_we, mem_oe;
  logic [7:0] mem_wdata;
  logic [2:0] opcode;
  logic       zero;
  logic [4:0] pc;
  logic       halted;
`ifdef INSTR_COUNT_EN
  logic [15:0] icount;
`endif

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  risc_datapath #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_acc(ld_acc),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .halt(halt), .data_e(data_e), .sel(sel),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_oe(mem_oe), .opcode(opcode), .zero(zero),
    .pc(pc), .halted(halted)
`ifdef INSTR_COUNT_EN
    , .icount(icount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd = 0; wr = 0; ld_ir = 0; ld_acc = 0; ld_pc = 0;
    inc_pc = 0; halt = 0; data_e = 0; sel = 0;
  endtask

  initial begin
    // Reset with every strobe asserted
    rst = 0; mem_rdata = 8'hFF;
    rd = 1; wr = 1; ld_ir = 1; ld_acc = 1; ld_pc = 1;
    inc_pc = 1; halt = 1; data_e = 1; sel = 1;
    #3;
    chk("rst_pc", pc, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_zero", zero, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_oe", mem_oe, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wdata", mem_wdata, 0);
    cycle();
    chk("rst_hold_pc", pc, 0);
    chk("rst_hold_halted", halted, 0);
`ifdef INSTR_COUNT_EN
    chk("rst_icount", icount, 0);
`endif
    idle(); rst = 1;

    // LDA then ADD with carry discarded
    ld_ir = 1; mem_rdata = 8'hA3; cycle();
    chk("lda_opcode", opcode, 5);
    ld_ir = 0; ld_acc = 1; mem_rdata = 8'h11; cycle();
    chk("lda_acc", mem_wdata, 8'h11);
    chk("lda_zero", zero, 0);
    ld_acc = 0; ld_ir = 1; mem_rdata = 8'h40; cycle();
    chk("add_opcode", opcode, 2);
    ld_ir = 0; ld_acc = 1; mem_rdata = 8'hF0; cycle();
    chk("add_acc", mem_wdata, 8'h01);

    // AND to zero
    ld_acc = 0; ld_ir = 1; mem_rdata = 8'hA0; cycle();
    ld_ir = 0; ld_acc = 1; mem_rdata = 8'h0F; cycle();
    chk("and_pre_acc", mem_wdata, 8'h0F);
    ld_acc = 0; ld_ir = 1; mem_rdata = 8'h60; cycle();
    ld_ir = 0; ld_acc = 1; mem_rdata = 8'hF0; cycle();
    chk("and_acc", mem_wdata, 8'h00);
    chk("and_zero", zero, 1);

    // Simultaneous ld_ir/ld_acc: ALU uses old opcode (AND), so ACC = 0 & A5
    ld_ir = 1; ld_acc = 1; mem_rdata = 8'hA5; cycle();
    chk("both_acc", mem_wdata, 8'h00);
    chk("both_opcode", opcode, 5);
    ld_ir = 0; mem_rdata = 8'h3C; cycle();
    chk("lda2_acc", mem_wdata, 8'h3C);
    ld_acc = 0; ld_ir = 1; mem_rdata = 8'h80; cycle();
    ld_ir = 0; ld_acc = 1; mem_rdata = 8'h0F; cycle();
    chk("xor_acc", mem_wdata, 8'h33);
    ld_acc = 0;

    // PC control: ld_pc wins over inc_pc, then wrap
    ld_ir = 1; mem_rdata = 8'hFD; cycle();
    chk("jmp_opcode", opcode, 7);
    ld_ir = 0; ld_pc = 1; inc_pc = 1; cycle();
    chk("jmp_pc", pc, 29);
    ld_pc = 0;
    cycle(); chk("inc_pc30", pc, 30);
    cycle(); chk("inc_pc31", pc, 31);
    cycle(); chk("inc_wrap", pc, 0);
    cycle(); cycle(); cycle(); cycle();
    chk("inc_pc4", pc, 4);
    inc_pc = 0;

    // STO and address mux
    ld_ir = 1; mem_rdata = 8'hA0; cycle();
    ld_ir = 0; ld_acc = 1; mem_rdata = 8'h5A; cycle();
    ld_acc = 0; ld_ir = 1; mem_rdata = 8'hC7; cycle();
    ld_ir = 0; sel = 0; wr = 1; data_e = 1; #1;
    chk("sto_addr", mem_addr, 7);
    chk("sto_we", mem_we, 1);
    chk("sto_oe", mem_oe, 1);
    chk("sto_wdata", mem_wdata, 8'h5A);
    chk("sto_re", mem_re, 0);
    sel = 1; rd = 1; #1;
    chk("sel_pc_addr", mem_addr, 4);
    chk("rd_re", mem_re, 1);
    idle();

    // Halt: the halting edge still loads, then everything freezes
    ld_ir = 1; mem_rdata = 8'hA0; cycle();
    ld_ir = 0; halt = 1; inc_pc = 1; ld_acc = 1; mem_rdata = 8'h5B; cycle();
    chk("halt_pc", pc, 5);
    chk("halt_flag", halted, 1);
    chk("halt_edge_acc", mem_wdata, 8'h5B);
    halt = 0; ld_ir = 1; mem_rdata = 8'h77; rd = 1; wr = 1; data_e = 1;
    for (int i = 0; i < 5; i++) cycle();
    chk("frozen_pc", pc, 5);
    chk("frozen_acc", mem_wdata, 8'h5B);
    chk("frozen_opcode", opcode, 5);
    chk("frozen_halted", halted, 1);
    chk("frozen_re", mem_re, 0);
    chk("frozen_we", mem_we, 0);
    chk("frozen_oe", mem_oe, 0);

    // Asynchronous reset mid-cycle clears halt
    #2 rst = 0; #1;
    chk("rerst_halted", halted, 0);
    chk("rerst_pc", pc, 0);
    chk("rerst_acc", mem_wdata, 0);
    idle(); cycle(); rst = 1;

    // Three fetches after reset
    ld_ir = 1; mem_rdata = 8'h20; cycle();
    mem_rdata = 8'h60; cycle();
    mem_rdata = 8'h80; cycle();
    ld_ir = 0;
    chk("fetch_opcode", opcode, 4);
`ifdef INSTR_COUNT_EN
    chk("icount3", icount, 3);
`endif
    cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/risc_datapath.md
Name: risc_datapath

Overview:
- Datapath at the other end of the VeriRisc sequence controller's control interface.
- Consumes the controller strobes rd, wr, ld_ir, ld_acc, ld_pc, inc_pc, halt, data_e and sel.
- Returns opcode and zero to the controller.
- Holds the program counter, instruction register, accumulator and ALU, and drives a simple synchronous-read memory port.

Parameters:
- AWIDTH, 5, address width (PC width and IR address field width).
- DWIDTH, 8, data/instruction width; DWIDTH must equal AWIDTH+3.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- rd  input  1  controller memory read strobe.
- wr  input  1  controller memory write strobe.
- ld_ir  input  1  load IR from mem_rdata.
- ld_acc  input  1  load ACC from ALU result.
- ld_pc  input  1  load PC from IR address field.
- inc_pc  input  1  increment PC.
- halt  input  1  halt request.
- data_e  input  1  enable ACC onto the write data bus.
- sel  input  1  address select: 1 = PC, 0 = IR address field.
- mem_rdata  input  DWIDTH  memory read data, valid in any cycle mem_re=1.
- mem_addr  output  AWIDTH  memory address.
- mem_re  output  1  memory read enable.
- mem_we  output  1  memory write enable.
- mem_wdata  output  DWIDTH  write data (ACC).
- mem_oe  output  1  write data bus drive enable.
- opcode  output  3  IR[DWIDTH-1:DWIDTH-3], to controller.
- zero  output  1  ACC == 0, to controller.
- pc  output  AWIDTH  current PC, for debug.
- halted  output  1  sticky halt status.

Behaviour:
- Reset (rst=0, asynchronous): PC=0, IR=0, ACC=0, halted=0.
  - Resulting outputs: opcode=0 (HLT), zero=1, mem_addr=0, mem_re=0, mem_we=0, mem_oe=0, mem_wdata=0.
- Combinational outputs:
  - mem_addr = sel ? PC : IR[AWIDTH-1:0].
  - mem_re = rd & ~halted.
  - mem_we = wr & ~halted.
  - mem_oe = data_e & ~halted.
  - mem_wdata = ACC.
  - zero = (ACC == 0).
  - opcode = IR top 3 bits.
- IR: on posedge with ld_ir=1 and halted=0, IR <= mem_rdata. The memory returns data in the same cycle; no extra latency.
- PC, evaluated on posedge with halted=0:
  - ld_pc=1: PC <= IR[AWIDTH-1:0]. ld_pc has priority over inc_pc when both are asserted.
  - else inc_pc=1: PC <= PC+1, modulo 2^AWIDTH, so 31 wraps to 0.
  - else PC holds.
- ACC: on posedge with ld_acc=1 and halted=0, ACC <= ALU result.
- ALU, selected by the current IR opcode; the result is computed against the pre-edge IR value:
  - 0 HLT, 1 SKZ, 6 STO, 7 JMP: pass ACC.
  - 2 ADD: ACC + mem_rdata, truncated to DWIDTH; carry discarded.
  - 3 AND: ACC & mem_rdata.
  - 4 XOR: ACC ^ mem_rdata.
  - 5 LDA: mem_rdata.
- Simultaneous ld_ir and ld_acc: both load. The ALU uses the old IR opcode.
- Halt:
  - halt=1 at a posedge sets halted=1, sticky until reset.
  - The same edge's ld_ir, ld_acc and ld_pc/inc_pc still take effect.
  - From the next edge on, PC, IR and ACC are frozen, and mem_re, mem_we and mem_oe are forced to 0.
- Reset mid-instruction: state is cleared immediately (asynchronous). The first posedge after rst deasserts behaves as a normal edge.
- The datapath has no internal state machine of its own. Phase sequencing belongs entirely to the controller. The datapath must tolerate any strobe combination, including all strobes active at once.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- When defined, adds output icount (16 bits):
  - Reset to 0.
  - Increments on each posedge with ld_ir=1 and halted=0.
  - Wraps from 0xFFFF to 0.
  - Counts retired fetches.
- When not defined, the icount port and its logic are absent and the rest of the block is identical.

Test Plan:
- Reset check:
  - Stimulus: drive rst=0 with all strobes at 1.
  - Required response: pc=0, opcode=0, zero=1, mem_we=0, mem_oe=0, halted=0.
- LDA then ADD:
  - Stimulus: mem_rdata=8'hA3 with ld_ir, giving opcode 5 (LDA). Then mem_rdata=8'h11 with ld_acc, giving ACC=8'h11 and zero=0.
  - Stimulus: load IR=8'h40 (ADD). Then mem_rdata=8'hF0 with ld_acc.
  - Required response: ACC=8'h01, overflow discarded.
- AND to zero:
  - Stimulus: ACC=8'h0F, IR opcode 3 (AND), mem_rdata=8'hF0, ld_acc.
  - Required response: ACC=0, zero=1.
- PC control:
  - Stimulus: IR=8'hFD (JMP to 29), assert ld_pc and inc_pc together.
  - Required response: pc=29.
  - Stimulus: then inc_pc for 3 edges.
  - Required response: pc=30, 31, 0.
- STO and address mux:
  - Stimulus: IR=8'hC7, ACC=8'h5A, sel=0, wr=1, data_e=1.
  - Required response: mem_addr=7, mem_we=1, mem_oe=1, mem_wdata=8'h5A.
  - Stimulus: sel=1.
  - Required response: mem_addr=pc.
- Halt freeze:
  - Stimulus: assert halt with inc_pc at pc=4, then keep inc_pc and ld_acc active for 5 edges.
  - Required response: pc=5 and stays 5, ACC unchanged, halted=1, mem_re=0.
  - Stimulus: rst low pulse.
  - Required response: halted=0, pc=0.
  - With INSTR_COUNT_EN: after 3 ld_ir edges, icount=3.
